mem_arbiter: RTL

- Arbitrates the single-ported core memory between two requesters: instruction fetch (I, read-only) and load/store unit (D, read/write).
- Issues at most one memory access per cycle and tracks the 1-cycle read latency to route read data back to its owner.
- Performs D-load sign/zero extension and applies a starvation guard so fetch always makes progress.
- Sits between the core pipeline and the memory block (4-byte little-endian read, 0/1/2/4-byte write).

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-ported core memory: fetch (read-only) vs load/store.
// Grants one access per cycle, routes 1-cycle read data back, extends D loads, guards against fetch starvation.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [1:0]  d_req_size,
    input  logic        d_req_unsigned,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic [1:0]  mem_wr,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_I    = 2'd1,
        RSP_D    = 2'd2
    } rsp_state_t;

    rsp_state_t       rsp_state;
    rsp_state_t       rsp_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             i_grant;
    logic             d_grant;
    logic             d_load_grant;
    logic [1:0]       lat_size;
    logic             lat_unsigned;

    // D normally wins; a fetch that has lost STARVE_LIMIT times in a row is forced through.
    always_comb begin
        d_grant      = !rst && d_req_valid && !(i_req_valid && (starve_cnt == CNT_MAX));
        i_grant      = !rst && i_req_valid && !d_grant;
        d_load_grant = d_grant && !d_req_we;
    end

    assign i_req_ready = i_grant;
    assign d_req_ready = d_grant;
    assign mem_rd_addr = d_grant ? d_req_addr : i_req_addr;
    assign mem_wr_addr = d_req_addr;
    assign mem_wr_data = d_req_wdata;

    always_comb begin
        mem_wr = 2'd0;
        if (d_grant && d_req_we) begin
            case (d_req_size)
                2'd0:    mem_wr = 2'd1;
                2'd1:    mem_wr = 2'd2;
                default: mem_wr = 2'd3;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (i_req_valid && d_grant) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_state <= RSP_NONE;
        end else begin
            rsp_state <= rsp_next;
        end
    end

    always_comb begin
        rsp_next = RSP_NONE;
        if (i_grant) begin
            rsp_next = RSP_I;
        end else if (d_load_grant) begin
            rsp_next = RSP_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
        end else if (d_load_grant) begin
            lat_size     <= d_req_size;
            lat_unsigned <= d_req_unsigned;
        end
    end

    assign i_rsp_valid = (rsp_state == RSP_I);
    assign i_rsp_data  = mem_rd_data;
    assign d_rsp_valid = (rsp_state == RSP_D);

    always_comb begin
        d_rsp_data = mem_rd_data;
        case (lat_size)
            2'd0:    d_rsp_data = {{24{!lat_unsigned && mem_rd_data[7]}}, mem_rd_data[7:0]};
            2'd1:    d_rsp_data = {{16{!lat_unsigned && mem_rd_data[15]}}, mem_rd_data[15:0]};
            default: d_rsp_data = mem_rd_data;
        endcase
    end

endmodule
